// File: rtl/parking_gate_controller_if.sv
// Gate-side signal bundle for parking_gate_controller.
// slave: controller view (requests and detector pulses in, gate state out).
// master: driver view (parking-lot top level or testbench).
interface parking_gate_controller_if #(
    parameter int unsigned CNT_W = 5
);
    logic             entry_req;
    logic             exit_req;
    logic             enter;
    logic             exit;
    logic             gate_open;
    logic             gate_dir;
    logic             entry_grant;
    logic             exit_grant;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             timeout_flag;

    modport slave (
        input  entry_req, exit_req, enter, exit,
        output gate_open, gate_dir, entry_grant, exit_grant,
        output occupancy, full, empty, timeout_flag
    );

    modport master (
        output entry_req, exit_req, enter, exit,
        input  gate_open, gate_dir, entry_grant, exit_grant,
        input  occupancy, full, empty, timeout_flag
    );
endinterface

// File: rtl/parking_gate_controller.sv
// Single-lane parking gate sequencer: round-robin arbitration between entry
// and exit requests, one direction open at a time, settle gap after each
// passage, and the lot occupancy count.
// Optional macro GATE_TIMEOUT_EN: force the gate closed after TIMEOUT cycles
// in a grant state without the matching passage pulse.
module parking_gate_controller #(
    parameter int unsigned CAPACITY   = 16,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned TIMEOUT    = 1000
) (
    input logic                      clk,
    input logic                      reset,
    parking_gate_controller_if.slave gate_if
);
    localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] Cap        = CNT_W'(CAPACITY);
    localparam logic [SetW-1:0]  SettleLoad = SetW'(SETTLE_CYC - 1);

    // Reject parameter sets the counters cannot represent.
    if (CAPACITY < 1 || (64'(1) << CNT_W) <= 64'(CAPACITY) || SETTLE_CYC < 1 || TIMEOUT < 1)
    begin : g_bad_param
        $error("parking_gate_controller: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StGrantIn, StGrantOut, StSettle} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] occ_q;
    logic [SetW-1:0]  settle_q;
    logic             last_in_q;   // 1: last grant went inbound
    logic             gate_open_q;
    logic             gate_dir_q;
    logic             entry_grant_q;
    logic             exit_grant_q;
    logic             full;
    logic             empty;
    logic             entry_ok;

`ifdef GATE_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
    logic [TmoW-1:0] tmo_q;
    logic            timeout_flag_q;
`endif

    assign full     = (occ_q == Cap);
    assign empty    = (occ_q == '0);
    assign entry_ok = gate_if.entry_req && !full;

    // FSM, occupancy, settle counter and registered Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            occ_q         <= '0;
            settle_q      <= '0;
            last_in_q     <= 1'b0;
            gate_open_q   <= 1'b0;
            gate_dir_q    <= 1'b0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
`ifdef GATE_TIMEOUT_EN
            tmo_q          <= '0;
            timeout_flag_q <= 1'b0;
`endif
        end else begin
            // Outputs follow the state one cycle later.
            gate_open_q   <= (state_q == StGrantIn) || (state_q == StGrantOut);
            gate_dir_q    <= (state_q == StGrantIn);
            entry_grant_q <= (state_q == StGrantIn);
            exit_grant_q  <= (state_q == StGrantOut);
`ifdef GATE_TIMEOUT_EN
            // Counter only survives while a grant state keeps incrementing it.
            tmo_q          <= '0;
            timeout_flag_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    // On a tie, serve the side that was not served last.
                    if (entry_ok && (!gate_if.exit_req || !last_in_q)) begin
                        state_q   <= StGrantIn;
                        last_in_q <= 1'b1;
                    end else if (gate_if.exit_req) begin
                        state_q   <= StGrantOut;
                        last_in_q <= 1'b0;
                    end
                end
                StGrantIn: begin
                    if (gate_if.enter) begin
                        if (!full) occ_q <= occ_q + 1'b1;
                        state_q  <= StSettle;
                        settle_q <= SettleLoad;
                    end
`ifdef GATE_TIMEOUT_EN
                    else if (tmo_q == TmoLast) begin
                        state_q        <= StSettle;
                        settle_q       <= SettleLoad;
                        timeout_flag_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                StGrantOut: begin
                    // A car may leave an empty lot; the count just stays at 0.
                    if (gate_if.exit) begin
                        if (!empty) occ_q <= occ_q - 1'b1;
                        state_q  <= StSettle;
                        settle_q <= SettleLoad;
                    end
`ifdef GATE_TIMEOUT_EN
                    else if (tmo_q == TmoLast) begin
                        state_q        <= StSettle;
                        settle_q       <= SettleLoad;
                        timeout_flag_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                StSettle: begin
                    if (settle_q == '0) state_q <= StIdle;
                    else                settle_q <= settle_q - 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gate_if.gate_open   = gate_open_q;
    assign gate_if.gate_dir    = gate_dir_q;
    assign gate_if.entry_grant = entry_grant_q;
    assign gate_if.exit_grant  = exit_grant_q;
    assign gate_if.occupancy   = occ_q;
    assign gate_if.full        = full;
    assign gate_if.empty       = empty;
`ifdef GATE_TIMEOUT_EN
    assign gate_if.timeout_flag = timeout_flag_q;
`else
    assign gate_if.timeout_flag = 1'b0;
`endif
endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller: reset, single entry timing,
// round-robin, full/empty boundaries, wrong-direction pulses, reset mid-grant
// and the optional timeout (GATE_TIMEOUT_EN).
module tb_parking_gate_controller;
`ifdef GATE_TIMEOUT_EN
    localparam int unsigned Timeout = 8;
`else
    localparam int unsigned Timeout = 1000;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    parking_gate_controller_if #(.CNT_W(5)) bus ();

    parking_gate_controller #(
        .CAPACITY  (16),
        .CNT_W     (5),
        .SETTLE_CYC(2),
        .TIMEOUT   (Timeout)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .gate_if(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the gate to open, then check which side got it.
    task automatic grant_wait(input logic exp_in);
        int n = 0;
        while (!bus.gate_open && n < 10) begin
            step();
            n++;
        end
        check_eq("grant_open", 32'(bus.gate_open), 1);
        check_eq("grant_in", 32'(bus.entry_grant), 32'(exp_in));
        check_eq("grant_out", 32'(bus.exit_grant), 32'(!exp_in));
        check_eq("gate_dir", 32'(bus.gate_dir), 32'(exp_in));
    endtask

    // One-cycle detector pulse, then ride out the settle gap back to idle.
    task automatic passage(input logic inb);
        if (inb) bus.enter = 1'b1;
        else     bus.exit  = 1'b1;
        step();
        bus.enter = 1'b0;
        bus.exit  = 1'b0;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got 0 expected 1");
        $fatal(1, "bench timed out");
    end

    initial begin
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.enter     = 1'b0;
        bus.exit      = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state.
        check_eq("rst_open", 32'(bus.gate_open), 0);
        check_eq("rst_egrant", 32'(bus.entry_grant), 0);
        check_eq("rst_xgrant", 32'(bus.exit_grant), 0);
        check_eq("rst_occ", 32'(bus.occupancy), 0);
        check_eq("rst_empty", 32'(bus.empty), 1);
        check_eq("rst_full", 32'(bus.full), 0);
        check_eq("rst_tmo", 32'(bus.timeout_flag), 0);

        // Single entry with exact latency and settle gap.
        bus.entry_req = 1'b1;
        step();
        check_eq("lat_n1_grant", 32'(bus.entry_grant), 0);
        step();
        check_eq("lat_n2_grant", 32'(bus.entry_grant), 1);
        check_eq("lat_n2_open", 32'(bus.gate_open), 1);
        check_eq("lat_n2_dir", 32'(bus.gate_dir), 1);
        bus.entry_req = 1'b0;
        bus.enter     = 1'b1;
        step();
        bus.enter = 1'b0;
        check_eq("enter_occ", 32'(bus.occupancy), 1);
        check_eq("enter_empty", 32'(bus.empty), 0);
        step();
        check_eq("settle1_open", 32'(bus.gate_open), 0);
        step();
        check_eq("settle2_open", 32'(bus.gate_open), 0);

        // Spurious pulses in idle are ignored.
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        bus.exit  = 1'b1;
        step();
        bus.exit = 1'b0;
        step();
        check_eq("spurious_occ", 32'(bus.occupancy), 1);
        check_eq("spurious_open", 32'(bus.gate_open), 0);

        // Three more entries (occ 4), one exit (occ 3, last served OUT).
        bus.entry_req = 1'b1;
        repeat (3) begin
            grant_wait(1'b1);
            passage(1'b1);
        end
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b1;
        grant_wait(1'b0);
        passage(1'b0);
        check_eq("pre_rr_occ", 32'(bus.occupancy), 3);

        // Both held: IN, OUT, IN, OUT.
        bus.entry_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            grant_wait(i % 2 == 0);
            passage(i % 2 == 0);
        end
        check_eq("rr_occ", 32'(bus.occupancy), 3);

        // Fill to capacity; entry must then be refused.
        bus.exit_req = 1'b0;
        repeat (13) begin
            grant_wait(1'b1);
            passage(1'b1);
        end
        check_eq("fill_occ", 32'(bus.occupancy), 16);
        check_eq("fill_full", 32'(bus.full), 1);
        repeat (5) step();
        check_eq("full_no_grant", 32'(bus.entry_grant), 0);
        check_eq("full_closed", 32'(bus.gate_open), 0);
        bus.exit_req = 1'b1;
        grant_wait(1'b0);
        passage(1'b0);
        check_eq("unfull_occ", 32'(bus.occupancy), 15);
        check_eq("unfull_full", 32'(bus.full), 0);
        grant_wait(1'b1);

        // Reset mid-grant clears immediately, without a clock edge.
        reset = 1'b1;
        #1;
        check_eq("rstmid_open", 32'(bus.gate_open), 0);
        check_eq("rstmid_egrant", 32'(bus.entry_grant), 0);
        check_eq("rstmid_occ", 32'(bus.occupancy), 0);
        check_eq("rstmid_empty", 32'(bus.empty), 1);
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Exit from an empty lot: count stays at 0, no wrap.
        bus.exit_req = 1'b1;
        grant_wait(1'b0);
        bus.exit_req = 1'b0;
        passage(1'b0);
        check_eq("empty_exit_occ", 32'(bus.occupancy), 0);
        check_eq("empty_exit_empty", 32'(bus.empty), 1);

        // Wrong-direction pulse and request drop during GRANT_IN.
        bus.entry_req = 1'b1;
        grant_wait(1'b1);
        bus.entry_req = 1'b0;
        bus.exit      = 1'b1;
        step();
        bus.exit = 1'b0;
        repeat (3) step();
        check_eq("wrongdir_open", 32'(bus.gate_open), 1);
        check_eq("wrongdir_grant", 32'(bus.entry_grant), 1);
        check_eq("wrongdir_occ", 32'(bus.occupancy), 0);
        passage(1'b1);
        check_eq("wrongdir_enter_occ", 32'(bus.occupancy), 1);

`ifdef GATE_TIMEOUT_EN
        // Grant with no passage: forced close after Timeout cycles.
        begin
            int n = 0;
            bus.entry_req = 1'b1;
            grant_wait(1'b1);
            bus.entry_req = 1'b0;
            while (!bus.timeout_flag && n < 20) begin
                step();
                n++;
            end
            check_eq("tmo_cycles", 32'(n), 32'(Timeout - 1));
            check_eq("tmo_flag", 32'(bus.timeout_flag), 1);
            check_eq("tmo_occ", 32'(bus.occupancy), 1);
            step();
            check_eq("tmo_pulse_end", 32'(bus.timeout_flag), 0);
            check_eq("tmo_closed", 32'(bus.gate_open), 0);
        end
`else
        // Without the timeout the grant waits indefinitely.
        begin
            int flag_seen = 0;
            bus.entry_req = 1'b1;
            grant_wait(1'b1);
            bus.entry_req = 1'b0;
            repeat (40) begin
                step();
                if (bus.timeout_flag) flag_seen++;
            end
            check_eq("hold_open", 32'(bus.gate_open), 1);
            check_eq("hold_no_tmo", 32'(flag_seen), 0);
            passage(1'b1);
            check_eq("hold_occ", 32'(bus.occupancy), 2);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
